led_pulse_stretch: RTL and testbench

- Output-side companion to the button input conditioning: takes short internal event pulses and drives human-visible LED blinks on board outputs.
- Each channel stretches a rising edge on evt_i into exactly OnCount cycles of LED on, followed by a GapCount-cycle forced off gap, so back-to-back events show as distinct blinks.
- One further event per channel is queued while a blink is in progress.
- Sits between status or event logic and the LED pins.

---
 rtl/led_pulse_stretch.sv | 166 ++++++++++++++++
 tb/tb_led_pulse_stretch.sv | 138 +++++++++++++
 2 files changed

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch
//   Turns short internal event pulses into human-visible LED blinks. Each
//   channel stretches a rising edge on evt_i into OnCount cycles of LED on,
//   followed by a GapCount-cycle forced-off gap. This keeps back-to-back
//   events visible as separate blinks. One further event per channel is
//   queued while a blink is in progress.
//
// Ports
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   evt_i      : [NumCh] event inputs, synchronous to clk_i, any pulse width
//   led_o      : [NumCh] registered LED drive
//   busy_o     : [NumCh] registered, channel not idle or has an event queued
//   overflow_o : [NumCh] registered one-cycle pulse when an event is dropped

module led_pulse_stretch_ch #(
  parameter int OnCount   = 500,
  parameter int GapCount  = 250,
  parameter bit Retrigger = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic evt_i,
  output logic led_o,
  output logic busy_o,
  output logic overflow_o
);

  localparam int MaxCnt = (OnCount > GapCount) ? OnCount : GapCount;
  localparam int CntW   = (MaxCnt > 1) ? $clog2(MaxCnt + 1) : 1;
  localparam logic [CntW-1:0] OnLast  = CntW'(OnCount - 1);
  // GAP is unreachable when GapCount == 0; the clamp keeps the constant legal.
  localparam logic [CntW-1:0] GapLast = CntW'((GapCount > 0) ? GapCount - 1 : 0);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            evt_q;
  logic            ovf_d;
  logic            evt;

  // Rising edge only: a held level yields one event. evt_q resets low, so a
  // level already high at reset release also counts once.
  assign evt = evt_i & ~evt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (Retrigger && evt) begin
          // Extend the blink; the queued event (if any) is untouched.
          cnt_d = '0;
        end else if (cnt_q == OnLast && GapCount == 0) begin
          // No gap: a queued or arriving event merges straight into a new
          // ON period. If both exist, one is consumed and one stays queued.
          if (pend_q || evt) begin
            cnt_d  = '0;
            pend_d = pend_q & evt;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          if (evt) begin
            if (pend_q) ovf_d  = 1'b1;
            else        pend_d = 1'b1;
          end
          if (cnt_q == OnLast) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (pend_q || evt) begin
            // An event on this cycle is consumed directly by the transition,
            // so a queued event survives only when both are present.
            state_d = ON;
            pend_d  = pend_q & evt;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (evt) begin
            if (pend_q) ovf_d  = 1'b1;
            else        pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      evt_q      <= 1'b0;
      led_o      <= 1'b0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      evt_q      <= evt_i;
      // Outputs are taken from next-state so they line up with the state.
      led_o      <= (state_d == ON);
      busy_o     <= (state_d != IDLE) | pend_d;
      overflow_o <= ovf_d;
    end
  end

endmodule

module led_pulse_stretch #(
  parameter int NumCh     = 8,
  parameter int OnCount   = 500,
  parameter int GapCount  = 250,
  parameter bit Retrigger = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] evt_i,
  output logic [NumCh-1:0] led_o,
  output logic [NumCh-1:0] busy_o,
  output logic [NumCh-1:0] overflow_o
);

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    led_pulse_stretch_ch #(
      .OnCount  (OnCount),
      .GapCount (GapCount),
      .Retrigger(Retrigger)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .evt_i     (evt_i[g]),
      .led_o     (led_o[g]),
      .busy_o    (busy_o[g]),
      .overflow_o(overflow_o[g])
    );
  end

endmodule

// File: tb/tb_led_pulse_stretch.sv
module tb_led_pulse_stretch;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] evt, evt_rt;
  logic [1:0] led, busy, ovf;
  logic [1:0] led_rt, busy_rt, ovf_rt;

  int vecs = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  led_pulse_stretch #(.NumCh(2), .OnCount(4), .GapCount(2), .Retrigger(1'b0)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .evt_i(evt),
    .led_o(led), .busy_o(busy), .overflow_o(ovf)
  );

  led_pulse_stretch #(.NumCh(2), .OnCount(4), .GapCount(2), .Retrigger(1'b1)) u_dut_rt (
    .clk_i(clk_i), .rst_ni(rst_ni), .evt_i(evt_rt),
    .led_o(led_rt), .busy_o(busy_rt), .overflow_o(ovf_rt)
  );

  task automatic chk(input string tag, input int cyc, input logic [1:0] got,
                     input logic [1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %b want %b", tag, cyc, got, exp);
    end
  endtask

  // Leaves the bench in cycle 0: just after the first edge with reset released.
  task automatic start();
    rst_ni = 1'b0;
    evt    = '0;
    evt_rt = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [1:0] in(input int c, input int lo, input int hi,
                                    input logic [1:0] v);
    return (c >= lo && c <= hi) ? v : 2'b00;
  endfunction

  initial begin
    // Reset state (asynchronous, before any clock edge).
    rst_ni = 1'b0;
    evt    = '0;
    evt_rt = '0;
    #2;
    chk("rst led", 0, led, 2'b00);
    chk("rst busy", 0, busy, 2'b00);
    chk("rst ovf", 0, ovf, 2'b00);

    // 1: single pulse, cycle 10.
    start();
    for (int c = 0; c < 25; c++) begin
      evt = (c == 10) ? 2'b01 : 2'b00;
      chk("t1 led", c, led, in(c, 11, 14, 2'b01));
      chk("t1 busy", c, busy, in(c, 11, 16, 2'b01));
      chk("t1 ovf", c, ovf, 2'b00);
      tick();
    end

    // 2: pulses 10, 12 -> two distinct blinks.
    start();
    for (int c = 0; c < 30; c++) begin
      evt = (c == 10 || c == 12) ? 2'b01 : 2'b00;
      chk("t2 led", c, led, in(c, 11, 14, 2'b01) | in(c, 17, 20, 2'b01));
      chk("t2 busy", c, busy, in(c, 11, 22, 2'b01));
      chk("t2 ovf", c, ovf, 2'b00);
      tick();
    end

    // 3: pulses 10, 12, 14 -> third one dropped, overflow in cycle 15.
    start();
    for (int c = 0; c < 30; c++) begin
      evt = (c == 10 || c == 12 || c == 14) ? 2'b01 : 2'b00;
      chk("t3 led", c, led, in(c, 11, 14, 2'b01) | in(c, 17, 20, 2'b01));
      chk("t3 busy", c, busy, in(c, 11, 22, 2'b01));
      chk("t3 ovf", c, ovf, in(c, 15, 15, 2'b01));
      tick();
    end

    // 4: Retrigger=1, pulses 10, 13 -> one extended blink 11-17.
    start();
    for (int c = 0; c < 28; c++) begin
      evt_rt = (c == 10 || c == 13) ? 2'b01 : 2'b00;
      chk("t4 led", c, led_rt, in(c, 11, 17, 2'b01));
      chk("t4 busy", c, busy_rt, in(c, 11, 19, 2'b01));
      chk("t4 ovf", c, ovf_rt, 2'b00);
      tick();
    end

    // 5: level held 10-40 gives one blink; then both channels in cycle 50.
    start();
    for (int c = 0; c < 62; c++) begin
      evt = (c >= 10 && c <= 40) ? 2'b01 : (c == 50) ? 2'b11 : 2'b00;
      chk("t5 led", c, led, in(c, 11, 14, 2'b01) | in(c, 51, 54, 2'b11));
      chk("t5 busy", c, busy, in(c, 11, 16, 2'b01) | in(c, 51, 56, 2'b11));
      chk("t5 ovf", c, ovf, 2'b00);
      tick();
    end

    // 6: reset mid-blink with an event queued.
    start();
    for (int c = 0; c < 12; c++) begin
      evt = (c == 8 || c == 10) ? 2'b01 : 2'b00;
      tick();
    end
    chk("t6 led pre", 12, led, 2'b01);
    chk("t6 busy pre", 12, busy, 2'b01);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6 led async", 12, led, 2'b00);
    chk("t6 busy async", 12, busy, 2'b00);
    chk("t6 ovf async", 12, ovf, 2'b00);
    tick();
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 15; c++) begin
      chk("t6 led post", c, led, 2'b00);
      chk("t6 busy post", c, busy, 2'b00);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
